// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the multiply/divide controller: operation codes seen
// from EXE, FSM state encoding, default operand width and a small op decoder.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // Default operand / HI / LO width
   localparam int unsigned XLEN_DEF = 32;

   // Field widths
   localparam int unsigned OP_W = 3;
   localparam int unsigned ST_W = 2;

   // EXE operation codes (6 and 7 are reserved and complete as no-ops)
   localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
   localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
   localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
   localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
   localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
   localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

   // Controller FSM encoding
   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_SEND = 2'd1;
   localparam logic [ST_W-1:0] ST_WAIT = 2'd2;
   localparam logic [ST_W-1:0] ST_DONE = 2'd3;

   // True for either divide flavour
   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the unsigned divide (selects the unsigned divider IP)
   function automatic logic is_divu_op(input logic [OP_W-1:0] op);
      return (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_stream_issue.sv
// -----------------------------------------------------------------------------
// div_stream_issue
// Drives the dividend/divisor AXI-stream valids of one divider IP. Both valids
// rise on i_start; each drops on the cycle after its own valid&ready, so the
// two channels may be accepted in any order or together. A valid is never
// withdrawn before acceptance.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   i_start              load pulse: raise both valids
//   i_dividend_tready    dividend channel ready from the IP
//   i_divisor_tready     divisor channel ready from the IP
//   o_dividend_tvalid    dividend channel valid
//   o_divisor_tvalid     divisor channel valid
//   o_pair_done_c        both channels accepted by the end of this cycle
// -----------------------------------------------------------------------------
module div_stream_issue (
   input  logic clk,
   input  logic resetn,
   input  logic i_start,
   input  logic i_dividend_tready,
   input  logic i_divisor_tready,
   output logic o_dividend_tvalid,
   output logic o_divisor_tvalid,
   output logic o_pair_done_c
);

   logic r_dvd_valid;
   logic r_dvs_valid;
   logic w_dvd_hs;
   logic w_dvs_hs;

   assign w_dvd_hs = r_dvd_valid & i_dividend_tready;
   assign w_dvs_hs = r_dvs_valid & i_divisor_tready;

   // Per-channel valid: set on start, cleared by its own handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dvd_valid <= 1'b0;
         r_dvs_valid <= 1'b0;
      end else begin
         if (i_start) begin
            r_dvd_valid <= 1'b1;
         end else if (w_dvd_hs) begin
            r_dvd_valid <= 1'b0;
         end
         if (i_start) begin
            r_dvs_valid <= 1'b1;
         end else if (w_dvs_hs) begin
            r_dvs_valid <= 1'b0;
         end
      end
   end

   // A channel is finished if already accepted or being accepted now
   assign o_pair_done_c = (~r_dvd_valid | i_dividend_tready) &
                          (~r_dvs_valid | i_divisor_tready);

   assign o_dividend_tvalid = r_dvd_valid;
   assign o_divisor_tvalid  = r_dvs_valid;

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Multiply/divide sequencer behind the EXE stage. Owns HI/LO, computes
// MULT/MULTU in one cycle, writes MTHI/MTLO, and runs DIV/DIVU through the
// external signed/unsigned divider IPs over AXI-stream, stalling EXE (busy)
// until the result lands. A flush during a divide lets the divider finish
// its protocol but discards the result.
//
// Optional feature macro: MULDIV_DIV0_BYPASS_EN
//   defined   : DIV/DIVU with src_rt==0 completes immediately with
//               hi <= src_rs, lo <= all-ones; the divider is not engaged.
//   undefined : divide-by-zero is forwarded to the divider like any divide.
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   op_valid, op_code             EXE request (held until op_done)
//   src_rs, src_rt                operands
//   flush                         kill current op, no architectural effect
//   op_done                       one-cycle completion pulse (combinational)
//   busy                          controller not idle
//   hi, lo                        HI/LO registers
//   div_dividend/divisor_tdata    operands latched at divide issue
//   sdiv_* / udiv_*               signed / unsigned divider stream ports
// -----------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] HILO_RST = '0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              op_valid,
   input  logic [OP_W-1:0]   op_code,
   input  logic [XLEN-1:0]   src_rs,
   input  logic [XLEN-1:0]   src_rt,
   input  logic              flush,
   output logic              op_done,
   output logic              busy,
   output logic [XLEN-1:0]   hi,
   output logic [XLEN-1:0]   lo,
   output logic [XLEN-1:0]   div_dividend_tdata,
   output logic [XLEN-1:0]   div_divisor_tdata,
   output logic              sdiv_dividend_tvalid,
   output logic              sdiv_divisor_tvalid,
   input  logic              sdiv_dividend_tready,
   input  logic              sdiv_divisor_tready,
   input  logic              sdiv_dout_tvalid,
   input  logic [2*XLEN-1:0] sdiv_dout_tdata,
   output logic              udiv_dividend_tvalid,
   output logic              udiv_divisor_tvalid,
   input  logic              udiv_dividend_tready,
   input  logic              udiv_divisor_tready,
   input  logic              udiv_dout_tvalid,
   input  logic [2*XLEN-1:0] udiv_dout_tdata
);

   localparam int unsigned PW = 2 * XLEN;

   // State and architectural registers
   logic [ST_W-1:0] r_state;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_dividend;
   logic [XLEN-1:0] r_divisor;
   logic            r_sel;      // 0 signed divider, 1 unsigned divider
   logic            r_cancel;   // in-flight divide was flushed

   // Next-state / combinational outputs
   logic [ST_W-1:0] w_state_nxt;
   logic [XLEN-1:0] w_hi_nxt;
   logic [XLEN-1:0] w_lo_nxt;
   logic [XLEN-1:0] w_dividend_nxt;
   logic [XLEN-1:0] w_divisor_nxt;
   logic            w_sel_nxt;
   logic            w_cancel_nxt;
   logic            w_op_done;
   logic            w_start_s;
   logic            w_start_u;

   logic            w_accept;
   logic            w_div0_byp;
   logic [PW-1:0]   w_prod_s;
   logic [PW-1:0]   w_prod_u;
   logic            w_s_pair_done;
   logic            w_u_pair_done;
   logic            w_pair_done;
   logic            w_dout_valid;
   logic [PW-1:0]   w_dout_data;
   logic            w_kill;

   assign w_accept = op_valid & ~flush;

   // Full-width products; operands extended to 2*XLEN before multiplying
   assign w_prod_s = $signed({{XLEN{src_rs[XLEN-1]}}, src_rs}) *
                     $signed({{XLEN{src_rt[XLEN-1]}}, src_rt});
   assign w_prod_u = {{XLEN{1'b0}}, src_rs} * {{XLEN{1'b0}}, src_rt};

`ifdef MULDIV_DIV0_BYPASS_EN
   assign w_div0_byp = (src_rt == '0);
`else
   assign w_div0_byp = 1'b0;
`endif

   // Only the divider chosen at issue is observed
   assign w_pair_done  = r_sel ? w_u_pair_done    : w_s_pair_done;
   assign w_dout_valid = r_sel ? udiv_dout_tvalid : sdiv_dout_tvalid;
   assign w_dout_data  = r_sel ? udiv_dout_tdata  : sdiv_dout_tdata;

   // A flush arriving with the result still discards it
   assign w_kill = r_cancel | flush;

   // Next-state and completion logic
   always_comb begin
      w_state_nxt    = r_state;
      w_hi_nxt       = r_hi;
      w_lo_nxt       = r_lo;
      w_dividend_nxt = r_dividend;
      w_divisor_nxt  = r_divisor;
      w_sel_nxt      = r_sel;
      w_cancel_nxt   = r_cancel;
      w_op_done      = 1'b0;
      w_start_s      = 1'b0;
      w_start_u      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cancel_nxt = 1'b0;
            if (w_accept) begin
               case (op_code)
                  MD_MULT: begin
                     {w_hi_nxt, w_lo_nxt} = w_prod_s;
                     w_op_done            = 1'b1;
                  end
                  MD_MULTU: begin
                     {w_hi_nxt, w_lo_nxt} = w_prod_u;
                     w_op_done            = 1'b1;
                  end
                  MD_MTHI: begin
                     w_hi_nxt  = src_rs;
                     w_op_done = 1'b1;
                  end
                  MD_MTLO: begin
                     w_lo_nxt  = src_rs;
                     w_op_done = 1'b1;
                  end
                  MD_DIV, MD_DIVU: begin
                     if (w_div0_byp) begin
                        w_hi_nxt  = src_rs;
                        w_lo_nxt  = '1;
                        w_op_done = 1'b1;
                     end else begin
                        w_dividend_nxt = src_rs;
                        w_divisor_nxt  = src_rt;
                        w_sel_nxt      = is_divu_op(op_code);
                        w_start_s      = ~is_divu_op(op_code);
                        w_start_u      = is_divu_op(op_code);
                        w_state_nxt    = ST_SEND;
                     end
                  end
                  default: begin
                     w_op_done = 1'b1;
                  end
               endcase
            end
         end

         ST_SEND: begin
            if (flush) begin
               w_cancel_nxt = 1'b1;
            end
            if (w_pair_done) begin
               w_state_nxt = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (w_dout_valid) begin
               if (w_kill) begin
                  w_state_nxt  = ST_IDLE;
                  w_cancel_nxt = 1'b0;
               end else begin
                  w_lo_nxt    = w_dout_data[PW-1:XLEN];
                  w_hi_nxt    = w_dout_data[XLEN-1:0];
                  w_state_nxt = ST_DONE;
               end
            end else if (flush) begin
               w_cancel_nxt = 1'b1;
            end
         end

         ST_DONE: begin
            // Result already committed; a flush here only hides the pulse
            w_op_done    = ~flush;
            w_state_nxt  = ST_IDLE;
            w_cancel_nxt = 1'b0;
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_cancel_nxt = 1'b0;
         end
      endcase
   end

   // State and register update
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_hi       <= HILO_RST;
         r_lo       <= HILO_RST;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_sel      <= 1'b0;
         r_cancel   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hi       <= w_hi_nxt;
         r_lo       <= w_lo_nxt;
         r_dividend <= w_dividend_nxt;
         r_divisor  <= w_divisor_nxt;
         r_sel      <= w_sel_nxt;
         r_cancel   <= w_cancel_nxt;
      end
   end

   // Signed divider stream issue
   div_stream_issue u_sdiv_issue (
      .clk               (clk),
      .resetn            (resetn),
      .i_start           (w_start_s),
      .i_dividend_tready (sdiv_dividend_tready),
      .i_divisor_tready  (sdiv_divisor_tready),
      .o_dividend_tvalid (sdiv_dividend_tvalid),
      .o_divisor_tvalid  (sdiv_divisor_tvalid),
      .o_pair_done_c     (w_s_pair_done)
   );

   // Unsigned divider stream issue
   div_stream_issue u_udiv_issue (
      .clk               (clk),
      .resetn            (resetn),
      .i_start           (w_start_u),
      .i_dividend_tready (udiv_dividend_tready),
      .i_divisor_tready  (udiv_divisor_tready),
      .o_dividend_tvalid (udiv_dividend_tvalid),
      .o_divisor_tvalid  (udiv_divisor_tvalid),
      .o_pair_done_c     (w_u_pair_done)
   );

   assign op_done            = w_op_done;
   assign busy               = (r_state != ST_IDLE);
   assign hi                 = r_hi;
   assign lo                 = r_lo;
   assign div_dividend_tdata = r_dividend;
   assign div_divisor_tdata  = r_divisor;

endmodule
